re_trans_timer_sched: RTL and testbench
=======================================

RE_TRANS_TIMER_SCHED -- requirements
Module: re_trans_timer_sched

Interface
REQ-001 SHALL have parameter WQE_INDEX_WIDTH, default 10, WQE id width.
REQ-002 SHALL have parameter PSN_WIDTH, default 24, PSN width.
REQ-003 SHALL have parameter SLOTS, default 8, number of tracked outstanding WQEs (power of 2, 2..32).
REQ-004 SHALL have parameter TIMER_WIDTH, default 16, per-slot timer width.
REQ-005 SHALL have parameter MAX_RETRY, default 3, retransmissions allowed before error.
REQ-006 SHALL have one clock, clk (input, 1 bit); all logic on its rising edge.
REQ-007 SHALL have rst_n (input, 1 bit), asynchronous, active-low reset.
REQ-008 SHALL have s_axis_tx_id, s_axis_tx_psn, s_axis_tx_valid (inputs; WQE_INDEX_WIDTH, PSN_WIDTH, 1) and s_axis_tx_ready (output, 1): packet-sent event.
REQ-009 SHALL have s_axis_ack_id, s_axis_ack_psn, s_axis_ack_valid (inputs; WQE_INDEX_WIDTH, PSN_WIDTH, 1) and s_axis_ack_ready (output, 1): ack event.
REQ-010 SHALL have cfg_timeout (input, TIMER_WIDTH): expiry threshold in clk cycles; 0 disables expiry.
REQ-011 SHALL have m_axis_rtx_id, m_axis_rtx_psn, m_axis_rtx_valid (outputs; WQE_INDEX_WIDTH, PSN_WIDTH, 1) and m_axis_rtx_ready (input, 1): retransmit request (resend from psn).
REQ-012 SHALL have m_axis_err_id, m_axis_err_valid (outputs; WQE_INDEX_WIDTH, 1) and m_axis_err_ready (input, 1): retry-exhausted report.
REQ-013 SHALL have stat_occupancy (output, $clog2(SLOTS)+1): count of valid slots.

Function
REQ-014 Each slot SHALL hold: valid, id, first_psn (oldest unacked), last_psn, timer, retry count.
REQ-015 Transfer on any stream SHALL occur only when valid and ready are both high at a rising edge.
REQ-016 s_axis_ack_ready SHALL be 1 whenever rst_n is high.
REQ-017 s_axis_tx_ready SHALL be combinational: 1 if s_axis_tx_id matches a valid slot or any slot is free; else 0.
REQ-018 Tx hit: slot last_psn <= tx_psn; timer, retry, first_psn unchanged.
REQ-019 Tx miss: allocate lowest-index free slot; first_psn = last_psn = tx_psn, timer 0, retry 0, valid 1.
REQ-020 Ack hit with ack_psn == last_psn: slot freed (valid 0) next cycle.
REQ-021 Ack hit otherwise: first_psn <= ack_psn + 1 (mod 2^PSN_WIDTH), timer 0, retry 0.
REQ-022 Ack miss: discarded, no state change.
REQ-023 Every valid slot's timer SHALL increment by 1 per cycle, saturating at all-ones; free slots hold 0.
REQ-024 Slot expired when valid, cfg_timeout != 0 and timer >= cfg_timeout.
REQ-025 FSM states SCAN, HOLD_RTX, HOLD_ERR; reset state SCAN.
REQ-026 SCAN: round-robin pointer examines one slot per cycle, advances by 1 mod SLOTS each cycle.
REQ-027 SCAN, examined slot expired, retry < MAX_RETRY: register id, first_psn onto rtx outputs, assert m_axis_rtx_valid next cycle, slot retry+1, timer 0; -> HOLD_RTX.
REQ-028 SCAN, examined slot expired, retry == MAX_RETRY: register id onto err outputs, assert m_axis_err_valid next cycle, free slot; -> HOLD_ERR.
REQ-029 HOLD_RTX/HOLD_ERR: outputs stable until ready; on handshake valid drops next cycle, -> SCAN, pointer resumes at next slot; pointer frozen while holding.
REQ-030 Same-cycle ack and expiry on the same slot: ack wins, no rtx/err issued that cycle.
REQ-031 Same-cycle tx and ack on the same slot: ack applied first, then tx update of last_psn; if ack would free the slot and tx hits it, slot stays valid with first_psn = last_psn = tx_psn, timer 0.
REQ-032 Same-cycle tx allocation and err-free: freed slot not available to tx until next cycle.
REQ-033 Duplicate ids SHALL never occupy two slots.

Reset
REQ-034 While rst_n low: all slots invalid, timers/retries 0, FSM SCAN, pointer 0, m_axis_rtx_valid 0, m_axis_err_valid 0, rtx/err id and psn 0, stat_occupancy 0, s_axis_ack_ready 0, s_axis_tx_ready 0.
REQ-035 Reset assertion mid-hold SHALL drop pending rtx/err valid immediately without handshake.

Verification
REQ-036 tx id 12 psn 0,1,2; ack 12 psn 2 before timeout (cfg_timeout 100) -> slot freed, no rtx, occupancy 1->0.
REQ-037 tx id 12 psn 0..2, ack psn 0, cfg_timeout 100, no further ack -> rtx id 12 psn 1 about 100+SLOTS cycles after ack; repeats 3 times, then err id 12, occupancy 0.
REQ-038 Fill 8 distinct ids -> s_axis_tx_ready 0 for new id 9, 1 for existing id; ack one fully -> id 9 accepted in freed lowest slot.
REQ-039 m_axis_rtx_ready held 0 for 50 cycles on pending rtx -> outputs stable, no other rtx/err issued, pointer frozen.
REQ-040 Ack and expiry same cycle on one slot -> no rtx; cfg_timeout 0 -> never rtx; rst_n low mid-HOLD_RTX -> valid 0 asynchronously.

Source files
------------

// File: rtl/re_trans_timer_sched.sv
// Retransmission timer scheduler: tracks outstanding WQEs per slot, ages them,
// and round-robin scans for expired slots to issue retransmit or retry-exhausted reports.
module re_trans_timer_sched #(
    parameter int unsigned WQE_INDEX_WIDTH = 10,
    parameter int unsigned PSN_WIDTH       = 24,
    parameter int unsigned SLOTS           = 8,
    parameter int unsigned TIMER_WIDTH     = 16,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [WQE_INDEX_WIDTH-1:0] s_axis_tx_id,
    input  logic [PSN_WIDTH-1:0]       s_axis_tx_psn,
    input  logic                       s_axis_tx_valid,
    output logic                       s_axis_tx_ready,

    input  logic [WQE_INDEX_WIDTH-1:0] s_axis_ack_id,
    input  logic [PSN_WIDTH-1:0]       s_axis_ack_psn,
    input  logic                       s_axis_ack_valid,
    output logic                       s_axis_ack_ready,

    input  logic [TIMER_WIDTH-1:0]     cfg_timeout,

    output logic [WQE_INDEX_WIDTH-1:0] m_axis_rtx_id,
    output logic [PSN_WIDTH-1:0]       m_axis_rtx_psn,
    output logic                       m_axis_rtx_valid,
    input  logic                       m_axis_rtx_ready,

    output logic [WQE_INDEX_WIDTH-1:0] m_axis_err_id,
    output logic                       m_axis_err_valid,
    input  logic                       m_axis_err_ready,

    output logic [$clog2(SLOTS):0]     stat_occupancy
);

    localparam int unsigned PTR_W = $clog2(SLOTS);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef struct packed {
        logic                       valid;
        logic [WQE_INDEX_WIDTH-1:0] id;
        logic [PSN_WIDTH-1:0]       first_psn;
        logic [PSN_WIDTH-1:0]       last_psn;
        logic [TIMER_WIDTH-1:0]     timer;
        logic [RTY_W-1:0]           retry;
    } slot_t;

    typedef enum logic [1:0] {
        SCAN,
        HOLD_RTX,
        HOLD_ERR
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    slot_t                slot_q [SLOTS];
    slot_t                slot_d [SLOTS];

    logic [SLOTS-1:0]     tx_hit_vec;
    logic [SLOTS-1:0]     ack_hit_vec;
    logic [SLOTS-1:0]     expired_vec;
    logic                 tx_hit;
    logic                 any_free;
    logic [PTR_W-1:0]     alloc_idx;
    logic                 tx_fire;
    logic                 ack_fire;
    logic                 scan_issue;
    logic                 issue_rtx;
    logic                 issue_err;
    logic                 slot_freed;
    logic [OCC_W-1:0]     occ_d;

    // Per-slot id match, expiry and lowest-index free slot search.
    always_comb begin
        tx_hit_vec  = '0;
        ack_hit_vec = '0;
        expired_vec = '0;
        any_free    = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            tx_hit_vec[i]  = slot_q[i].valid && (slot_q[i].id == s_axis_tx_id);
            ack_hit_vec[i] = slot_q[i].valid && (slot_q[i].id == s_axis_ack_id);
            expired_vec[i] = slot_q[i].valid && (cfg_timeout != '0) &&
                             (slot_q[i].timer >= cfg_timeout);
        end
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (!slot_q[i].valid) begin
                any_free  = 1'b1;
                alloc_idx = PTR_W'(i);
            end
        end
    end

    assign tx_hit           = |tx_hit_vec;
    assign s_axis_tx_ready  = rst_n & (tx_hit | any_free);
    assign s_axis_ack_ready = rst_n;
    assign tx_fire          = s_axis_tx_valid & s_axis_tx_ready;
    assign ack_fire         = s_axis_ack_valid & s_axis_ack_ready;

    // An ack on the examined slot suppresses its expiry in the same cycle.
    assign scan_issue = (state_q == SCAN) && expired_vec[ptr_q] &&
                        !(ack_fire && ack_hit_vec[ptr_q]);
    assign issue_rtx  = scan_issue && (slot_q[ptr_q].retry < RTY_W'(MAX_RETRY));
    assign issue_err  = scan_issue && !(slot_q[ptr_q].retry < RTY_W'(MAX_RETRY));

    // Slot next-state: ack first, then scan action, then tx update/allocation.
    always_comb begin
        slot_freed = 1'b0;
        occ_d      = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            slot_d[i]  = slot_q[i];
            slot_freed = 1'b0;
            if (slot_q[i].valid && (slot_q[i].timer != '1)) begin
                slot_d[i].timer = slot_q[i].timer + TIMER_WIDTH'(1);
            end
            if (ack_fire && ack_hit_vec[i]) begin
                slot_d[i].timer = '0;
                slot_d[i].retry = '0;
                if (s_axis_ack_psn == slot_q[i].last_psn) begin
                    slot_d[i].valid = 1'b0;
                    slot_freed      = 1'b1;
                end else begin
                    slot_d[i].first_psn = s_axis_ack_psn + PSN_WIDTH'(1);
                end
            end else if (scan_issue && (ptr_q == PTR_W'(i))) begin
                slot_d[i].timer = '0;
                if (issue_rtx) begin
                    slot_d[i].retry = slot_q[i].retry + RTY_W'(1);
                end else begin
                    slot_d[i].valid = 1'b0;
                    slot_d[i].retry = '0;
                    slot_freed      = 1'b1;
                end
            end
            if (tx_fire && tx_hit_vec[i]) begin
                slot_d[i].last_psn = s_axis_tx_psn;
                if (slot_freed) begin
                    slot_d[i].valid     = 1'b1;
                    slot_d[i].first_psn = s_axis_tx_psn;
                    slot_d[i].timer     = '0;
                    slot_d[i].retry     = '0;
                end
            end else if (tx_fire && !tx_hit && (alloc_idx == PTR_W'(i))) begin
                slot_d[i].valid     = 1'b1;
                slot_d[i].id        = s_axis_tx_id;
                slot_d[i].first_psn = s_axis_tx_psn;
                slot_d[i].last_psn  = s_axis_tx_psn;
                slot_d[i].timer     = '0;
                slot_d[i].retry     = '0;
            end
            occ_d = occ_d + OCC_W'(slot_d[i].valid);
        end
    end

    // Slot storage and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                slot_q[i] <= '0;
            end
            stat_occupancy <= '0;
        end else begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                slot_q[i] <= slot_d[i];
            end
            stat_occupancy <= occ_d;
        end
    end

    // Scan/hold FSM with registered rtx/err outputs; pointer frozen while holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= SCAN;
            ptr_q            <= '0;
            m_axis_rtx_id    <= '0;
            m_axis_rtx_psn   <= '0;
            m_axis_rtx_valid <= 1'b0;
            m_axis_err_id    <= '0;
            m_axis_err_valid <= 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    ptr_q <= ptr_q + PTR_W'(1);
                    if (issue_rtx) begin
                        m_axis_rtx_id    <= slot_q[ptr_q].id;
                        m_axis_rtx_psn   <= slot_q[ptr_q].first_psn;
                        m_axis_rtx_valid <= 1'b1;
                        state_q          <= HOLD_RTX;
                    end else if (issue_err) begin
                        m_axis_err_id    <= slot_q[ptr_q].id;
                        m_axis_err_valid <= 1'b1;
                        state_q          <= HOLD_ERR;
                    end
                end
                HOLD_RTX: begin
                    if (m_axis_rtx_ready) begin
                        m_axis_rtx_valid <= 1'b0;
                        state_q          <= SCAN;
                    end
                end
                HOLD_ERR: begin
                    if (m_axis_err_ready) begin
                        m_axis_err_valid <= 1'b0;
                        state_q          <= SCAN;
                    end
                end
                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_re_trans_timer_sched.sv
// Self-checking bench for re_trans_timer_sched: vector table for slot bookkeeping,
// scoreboard queue for rtx/err output streams, directed multi-cycle corner cases.
module tb_re_trans_timer_sched;

    localparam int IW = 10;
    localparam int PW = 24;
    localparam int TW = 16;
    localparam int SL = 8;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] s_axis_tx_id;
    logic [PW-1:0] s_axis_tx_psn;
    logic          s_axis_tx_valid;
    logic          s_axis_tx_ready;
    logic [IW-1:0] s_axis_ack_id;
    logic [PW-1:0] s_axis_ack_psn;
    logic          s_axis_ack_valid;
    logic          s_axis_ack_ready;
    logic [TW-1:0] cfg_timeout;
    logic [IW-1:0] m_axis_rtx_id;
    logic [PW-1:0] m_axis_rtx_psn;
    logic          m_axis_rtx_valid;
    logic          m_axis_rtx_ready;
    logic [IW-1:0] m_axis_err_id;
    logic          m_axis_err_valid;
    logic          m_axis_err_ready;
    logic [3:0]    stat_occupancy;

    re_trans_timer_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tx_id     (s_axis_tx_id),
        .s_axis_tx_psn    (s_axis_tx_psn),
        .s_axis_tx_valid  (s_axis_tx_valid),
        .s_axis_tx_ready  (s_axis_tx_ready),
        .s_axis_ack_id    (s_axis_ack_id),
        .s_axis_ack_psn   (s_axis_ack_psn),
        .s_axis_ack_valid (s_axis_ack_valid),
        .s_axis_ack_ready (s_axis_ack_ready),
        .cfg_timeout      (cfg_timeout),
        .m_axis_rtx_id    (m_axis_rtx_id),
        .m_axis_rtx_psn   (m_axis_rtx_psn),
        .m_axis_rtx_valid (m_axis_rtx_valid),
        .m_axis_rtx_ready (m_axis_rtx_ready),
        .m_axis_err_id    (m_axis_err_id),
        .m_axis_err_valid (m_axis_err_valid),
        .m_axis_err_ready (m_axis_err_ready),
        .stat_occupancy   (stat_occupancy)
    );

    typedef struct packed {
        logic          is_err;
        logic [IW-1:0] id;
        logic [PW-1:0] psn;
    } exp_t;

    typedef struct {
        logic          tv;
        logic [IW-1:0] tid;
        logic [PW-1:0] tpsn;
        logic          av;
        logic [IW-1:0] aid;
        logic [PW-1:0] apsn;
        logic          exp_rdy;
        int            exp_occ;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   first_rtx_cyc = 0;
    logic rtx_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic tv, input logic [IW-1:0] tid, input logic [PW-1:0] tp,
                         input logic av, input logic [IW-1:0] aid, input logic [PW-1:0] ap);
        s_axis_tx_valid  = tv;
        s_axis_tx_id     = tid;
        s_axis_tx_psn    = tp;
        s_axis_ack_valid = av;
        s_axis_ack_id    = aid;
        s_axis_ack_psn   = ap;
    endtask

    function automatic void add(input logic tv, input int tid, input int tp, input logic av,
                                input int aid, input int ap, input logic rdy, input int occ);
        vec_t v;
        v.tv = tv; v.tid = IW'(tid); v.tpsn = PW'(tp);
        v.av = av; v.aid = IW'(aid); v.apsn = PW'(ap);
        v.exp_rdy = rdy; v.exp_occ = occ;
        vecs.push_back(v);
    endfunction

    task automatic wait_q_empty(input int max, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check(nm, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_rtx_valid(input int max, input string nm);
        int n = 0;
        while (!m_axis_rtx_valid && n < max) begin
            tick();
            n++;
        end
        check(nm, 64'(m_axis_rtx_valid), 64'd1);
    endtask

    // Scoreboard: every completed rtx/err handshake must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_rtx_valid && m_axis_rtx_ready) begin
                if (!rtx_seen) begin
                    rtx_seen      = 1'b1;
                    first_rtx_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_rtx", 64'({1'b0, m_axis_rtx_id, m_axis_rtx_psn}), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rtx_stream", 64'({1'b0, m_axis_rtx_id, m_axis_rtx_psn}), 64'(e));
                end
            end
            if (m_axis_err_valid && m_axis_err_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_err", 64'({1'b1, m_axis_err_id, PW'(0)}), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("err_stream", 64'({1'b1, m_axis_err_id, PW'(0)}), 64'(e));
                end
            end
        end
    end

    initial begin
        int   ack_cyc;
        logic stable;

        rst_n            = 1'b0;
        cfg_timeout      = '0;
        m_axis_rtx_ready = 1'b1;
        m_axis_err_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // Table: bookkeeping, fill/full behaviour, ack variants, same-cycle tx+ack.
        add(1, 12, 0,   0, 0, 0,   1, 1);
        add(1, 12, 1,   0, 0, 0,   1, 1);
        add(1, 12, 2,   0, 0, 0,   1, 1);
        add(0, 0,  0,   1, 12, 2,  1, 0);
        add(0, 0,  0,   1, 5, 0,   1, 0);
        for (int k = 1; k <= SL; k++) add(1, k, 100 + k, 0, 0, 0, 1, k);
        add(0, 9, 0,    0, 0, 0,   0, 8);
        add(1, 9, 0,    0, 0, 0,   0, 8);
        add(1, 3, 200,  0, 0, 0,   1, 8);
        add(0, 9, 0,    1, 1, 101, 0, 7);
        add(1, 9, 300,  0, 0, 0,   1, 8);
        add(1, 9, 301,  1, 9, 300, 1, 8);
        add(0, 9, 0,    1, 9, 301, 1, 7);
        add(0, 0, 0,    1, 3, 103, 1, 7);
        add(0, 0, 0,    1, 3, 200, 1, 6);
        add(0, 0, 0,    1, 2, 102, 1, 5);
        for (int k = 4; k <= SL; k++) add(0, 0, 0, 1, k, 100 + k, 1, SL - k);
        add(0, 0, 0,    1, 9, 301, 1, 0);

        #1;
        check("rst_rtx_valid", 64'(m_axis_rtx_valid), 64'd0);
        check("rst_err_valid", 64'(m_axis_err_valid), 64'd0);
        check("rst_occupancy", 64'(stat_occupancy), 64'd0);
        check("rst_tx_ready", 64'(s_axis_tx_ready), 64'd0);
        check("rst_ack_ready", 64'(s_axis_ack_ready), 64'd0);
        check("rst_rtx_id", 64'({m_axis_rtx_id, m_axis_rtx_psn, m_axis_err_id}), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ack_ready", 64'(s_axis_ack_ready), 64'd1);
        check("post_rst_tx_ready", 64'(s_axis_tx_ready), 64'd1);
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].tv, vecs[i].tid, vecs[i].tpsn, vecs[i].av, vecs[i].aid, vecs[i].apsn);
            #1;
            check($sformatf("vec%0d_tx_ready", i), 64'(s_axis_tx_ready), 64'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d_occupancy", i), 64'(stat_occupancy), 64'(vecs[i].exp_occ));
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();

        // Three retransmits from psn 1, then retry exhaustion.
        cfg_timeout = TW'(100);
        rtx_seen    = 1'b0;
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, IW'(12), PW'(p), 1'b0, '0, '0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, IW'(12), PW'(0));
        tick();
        ack_cyc = cyc;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check("retry_occ_after_ack", 64'(stat_occupancy), 64'd1);
        for (int r = 0; r < 3; r++) exp_q.push_back({1'b0, IW'(12), PW'(1)});
        exp_q.push_back({1'b1, IW'(12), PW'(0)});
        wait_q_empty(1000, "retry_sequence_done");
        check("first_rtx_latency_in_window",
              64'((first_rtx_cyc - ack_cyc >= 100) && (first_rtx_cyc - ack_cyc <= 100 + SL + 1)),
              64'd1);
        tick();
        check("retry_occ_after_err", 64'(stat_occupancy), 64'd0);
        check("retry_no_pending", 64'({m_axis_rtx_valid, m_axis_err_valid}), 64'd0);

        // Backpressured rtx: outputs hold, pointer frozen, then order resumes at next slot.
        cfg_timeout      = TW'(20);
        m_axis_rtx_ready = 1'b0;
        drive(1'b1, IW'(7), PW'(50), 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        wait_rtx_valid(200, "hold_rtx_appears");
        check("hold_rtx_payload", 64'({m_axis_rtx_id, m_axis_rtx_psn}), 64'({IW'(7), PW'(50)}));
        drive(1'b1, IW'(8), PW'(60), 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (!m_axis_rtx_valid || m_axis_rtx_id != IW'(7) || m_axis_rtx_psn != PW'(50) ||
                m_axis_err_valid)
                stable = 1'b0;
            tick();
        end
        check("hold_outputs_stable", 64'(stable), 64'd1);
        check("hold_occupancy", 64'(stat_occupancy), 64'd2);
        exp_q.push_back({1'b0, IW'(7), PW'(50)});
        exp_q.push_back({1'b0, IW'(8), PW'(60)});
        exp_q.push_back({1'b0, IW'(7), PW'(50)});
        m_axis_rtx_ready = 1'b1;
        wait_q_empty(200, "hold_release_order");
        cfg_timeout = '0;
        drive(1'b0, '0, '0, 1'b1, IW'(7), PW'(50));
        tick();
        drive(1'b0, '0, '0, 1'b1, IW'(8), PW'(60));
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check("hold_cleanup_occ", 64'(stat_occupancy), 64'd0);

        // Reset asserted mid-hold drops valid without a handshake.
        cfg_timeout      = TW'(10);
        m_axis_rtx_ready = 1'b0;
        drive(1'b1, IW'(6), PW'(77), 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        wait_rtx_valid(100, "pre_reset_rtx");
        check("pre_reset_payload", 64'({m_axis_rtx_id, m_axis_rtx_psn}), 64'({IW'(6), PW'(77)}));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_rtx_valid", 64'(m_axis_rtx_valid), 64'd0);
        check("async_rst_payload", 64'({m_axis_rtx_id, m_axis_rtx_psn}), 64'd0);
        check("async_rst_occ", 64'(stat_occupancy), 64'd0);
        check("async_rst_readies", 64'({s_axis_tx_ready, s_axis_ack_ready}), 64'd0);
        tick();
        tick();
        cfg_timeout      = '0;
        m_axis_rtx_ready = 1'b1;
        rst_n            = 1'b1;

        // Pointer starts at 0 after reset: edge 16 examines slot 0 while it is acked.
        drive(1'b1, IW'(4), PW'(10), 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (15) tick();
        cfg_timeout = TW'(5);
        drive(1'b0, '0, '0, 1'b1, IW'(4), PW'(9));
        tick();
        cfg_timeout = '0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check("ack_beats_expiry", 64'({m_axis_rtx_valid, m_axis_err_valid}), 64'd0);
        repeat (300) tick();
        check("timeout_zero_no_rtx", 64'({m_axis_rtx_valid, m_axis_err_valid}), 64'd0);
        check("timeout_zero_occ", 64'(stat_occupancy), 64'd1);
        drive(1'b0, '0, '0, 1'b1, IW'(4), PW'(10));
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check("final_occ", 64'(stat_occupancy), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
